// File: rtl/labx_buffer_pkg.sv
// Shared constants and types for the LAB sample buffer: Wishbone codes,
// status page layout and the per-channel control/response bundles.
package labx_buffer_pkg;

  localparam logic [3:0]  STATUS_CH   = 4'hF;
  localparam logic [1:0]  OVF         = 2'd0;
  localparam logic [1:0]  UNF         = 2'd1;
  localparam logic [1:0]  PEMPTY      = 2'd2;
  localparam logic [1:0]  INFO        = 2'd3;
  localparam logic [31:0] EMPTY_FILL  = 32'hDEAD_BEEF;
  localparam logic [2:0]  CTI_CLASSIC = 3'b000;
  localparam logic [2:0]  CTI_INCR    = 3'b010;
  localparam logic [2:0]  CTI_END     = 3'b111;

  typedef enum logic {ST_IDLE, ST_ACK} wb_state_e;

  typedef struct packed {
    logic rd;
    logic clr_ovf;
    logic clr_unf;
  } chan_ctl_t;

  typedef struct packed {
    logic [31:0] q;
    logic        empty;
    logic        ovf;
    logic        unf;
    logic        pempty;
  } chan_rsp_t;

endpackage

// File: rtl/labx_chan_fifo.sv
// One channel: pairs 16-bit entries into 32-bit words held in a circular RAM,
// with count, sticky overflow/underflow and registered programmable-empty.
module labx_chan_fifo
  import labx_buffer_pkg::*;
#(
  parameter int DEPTH = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_fifo_rst,
  input  logic                       i_wr,
  input  logic [15:0]                i_entry,
  input  chan_ctl_t                  i_ctl,
  input  logic [$clog2(DEPTH/2):0]   i_thresh,
  output chan_rsp_t                  o_rsp
);

  localparam int WD = DEPTH / 2;
  localparam int AW = $clog2(WD);

  logic [31:0]   r_mem [WD];
  logic [31:0]   r_q;
  logic [15:0]   r_half;
  logic          r_hsel, r_push_d, r_ovf, r_unf, r_pe;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_cnt;
  logic          w_empty, w_full, w_commit, w_pop;

  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == (AW+1)'(WD));
  assign w_commit = i_wr & r_hsel & ~w_full;
  assign w_pop    = i_ctl.rd & ~w_empty;

  always_ff @(posedge i_clk) begin
    if (i_rst | i_fifo_rst) begin
      r_hsel   <= 1'b0;
      r_half   <= '0;
      r_push_d <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      // count sees a commit one cycle late so a same-cycle read never races the RAM write
      r_push_d <= w_commit;
      r_cnt    <= r_cnt + (AW+1)'(r_push_d) - (AW+1)'(w_pop);
      if (i_wr) begin
        r_hsel <= ~r_hsel;
        if (!r_hsel) r_half <= i_entry;
      end
      if (w_commit) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= (r_ovf & ~i_ctl.clr_ovf) | (i_wr & r_hsel & w_full);
      r_unf <= (r_unf & ~i_ctl.clr_unf) | (i_ctl.rd & w_empty);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_pe <= 1'b1;
    else       r_pe <= (r_cnt <= i_thresh);
  end

  // reading the look-ahead address on a pop keeps bursts at one word per cycle
  always_ff @(posedge i_clk) begin
    if (w_commit) r_mem[r_wr_ptr] <= {i_entry, r_half};
    r_q <= r_mem[r_rd_ptr + AW'(w_pop)];
  end

  assign o_rsp = '{q: r_q, empty: w_empty, ovf: r_ovf, unf: r_unf, pempty: r_pe};

endmodule

// File: rtl/labx_sample_buffer.sv
// LAB readout buffer: NCH channel FIFOs behind a Wishbone slave with bursts and
// a status page. Optional test-pattern counter enabled by LABX_TEST_PATTERN_EN.
module labx_sample_buffer
  import labx_buffer_pkg::*;
#(
  parameter int NCH      = 12,
  parameter int SAMPLE_W = 12,
  parameter int DEPTH    = 1024,
  parameter int CH_LSB   = $clog2(DEPTH) + 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wb_cyc_i,
  input  logic                        wb_stb_i,
  input  logic                        wb_we_i,
  input  logic [15:0]                 wb_adr_i,
  input  logic [31:0]                 wb_dat_i,
  input  logic [3:0]                  wb_sel_i,
  input  logic [2:0]                  wb_cti_i,
  output logic [31:0]                 wb_dat_o,
  output logic                        wb_ack_o,
  input  logic                        wr_i,
  input  logic [NCH*SAMPLE_W-1:0]     wr_dat_i,
  input  logic [15-SAMPLE_W:0]        wr_hdr_i,
  input  logic                        fifo_rst_i,
  input  logic [$clog2(DEPTH/2):0]    empty_thresh_i,
  input  logic                        test_pattern_i,
  output logic [NCH-1:0]              prog_empty_o
);

  localparam int WD = DEPTH / 2;

  wb_state_e              r_state, w_state_nx;
  logic                   w_req, w_ack, w_fifo, w_stat, w_fifo_empty, w_unused;
  logic [3:0]             w_ch;
  logic [1:0]             w_off;
  logic [31:0]            w_fifo_q;
  logic [NCH-1:0]         w_ovf, w_unf;
  chan_ctl_t [NCH-1:0]    w_ctl;
  chan_rsp_t [NCH-1:0]    w_rsp;

  assign w_req    = wb_cyc_i & wb_stb_i;
  assign w_ack    = (r_state == ST_ACK) & w_req;
  assign w_ch     = wb_adr_i[CH_LSB +: 4];
  assign w_off    = wb_adr_i[3:2];
  assign w_fifo   = (32'(w_ch) < NCH);
  assign w_stat   = (w_ch == STATUS_CH);
  assign wb_ack_o = w_ack;
  assign w_unused = ^{wb_sel_i, wb_adr_i, wb_dat_i, test_pattern_i};

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ST_IDLE: if (w_req) w_state_nx = ST_ACK;
      ST_ACK:  if (!w_req || wb_cti_i != CTI_INCR) w_state_nx = ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

`ifdef LABX_TEST_PATTERN_EN
  logic [SAMPLE_W-1:0] r_tp_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i | fifo_rst_i) r_tp_cnt <= '0;
    else if (wr_i)          r_tp_cnt <= r_tp_cnt + 1'b1;
  end
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [SAMPLE_W-1:0] w_samp;
`ifdef LABX_TEST_PATTERN_EN
    assign w_samp = test_pattern_i ? r_tp_cnt + SAMPLE_W'(c) : wr_dat_i[c*SAMPLE_W +: SAMPLE_W];
`else
    assign w_samp = wr_dat_i[c*SAMPLE_W +: SAMPLE_W];
`endif
    assign w_ctl[c] = '{
      rd:      w_ack & ~wb_we_i & w_fifo & (w_ch == 4'(c)),
      clr_ovf: w_ack & wb_we_i & w_stat & (w_off == OVF) & wb_dat_i[c],
      clr_unf: w_ack & wb_we_i & w_stat & (w_off == UNF) & wb_dat_i[c]
    };
    assign w_ovf[c]        = w_rsp[c].ovf;
    assign w_unf[c]        = w_rsp[c].unf;
    assign prog_empty_o[c] = w_rsp[c].pempty;

    labx_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
      .i_clk      (clk_i),
      .i_rst      (rst_i),
      .i_fifo_rst (fifo_rst_i),
      .i_wr       (wr_i),
      .i_entry    ({wr_hdr_i, w_samp}),
      .i_ctl      (w_ctl[c]),
      .i_thresh   (empty_thresh_i),
      .o_rsp      (w_rsp[c])
    );
  end

  // data is only driven during a read ack; idle bus reads as zero
  always_comb begin
    w_fifo_q     = '0;
    w_fifo_empty = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (w_ch == 4'(c)) begin
        w_fifo_q     = w_rsp[c].q;
        w_fifo_empty = w_rsp[c].empty;
      end
    end
    wb_dat_o = '0;
    if (w_ack && !wb_we_i) begin
      if (w_fifo) begin
        wb_dat_o = w_fifo_empty ? EMPTY_FILL : w_fifo_q;
      end else if (w_stat) begin
        unique case (w_off)
          OVF:     wb_dat_o = 32'(w_ovf);
          UNF:     wb_dat_o = 32'(w_unf);
          PEMPTY:  wb_dat_o = 32'(prog_empty_o);
          default: wb_dat_o = {16'(NCH), 16'(WD)};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_labx_sample_buffer.sv
// Scoreboard bench for labx_sample_buffer: stimulus queues expected read data,
// a negedge monitor compares every read ack against the queue.
module tb_labx_sample_buffer;
  import labx_buffer_pkg::*;

  localparam int NCH = 12;
  localparam int SW  = 12;
  localparam int DEPTH = 1024;
  localparam int WD = DEPTH / 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = '0;
  logic [31:0] dat_i = '0;
  logic [2:0]  cti = CTI_CLASSIC;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wr = 1'b0;
  logic [NCH*SW-1:0] wr_dat = '0;
  logic [3:0]  wr_hdr = '0;
  logic        fifo_rst = 1'b0;
  logic [9:0]  thresh = '0;
  logic        tp = 1'b0;
  logic [NCH-1:0] prog_empty_o;

  int checks = 0;
  int failures = 0;
  string       nm_q[$];
  logic [31:0] dat_q[$];
  logic [31:0] model[$];

  always #5 clk = ~clk;

  labx_sample_buffer #(.NCH(NCH), .SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(4'hF), .wb_cti_i(cti),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wr_i(wr), .wr_dat_i(wr_dat),
    .wr_hdr_i(wr_hdr), .fifo_rst_i(fifo_rst), .empty_thresh_i(thresh),
    .test_pattern_i(tp), .prog_empty_o(prog_empty_o)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // monitor: every read ack pops one expected word
  always @(negedge clk) begin
    if (wb_ack_o && !we) begin
      if (dat_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ack actual=%h expected=none", wb_dat_o);
      end else begin
        chk(nm_q.pop_front(), wb_dat_o, dat_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_rd(string nm, logic [31:0] d);
    nm_q.push_back(nm); dat_q.push_back(d);
  endtask

  task automatic set_samp(logic [3:0] hdr, logic [11:0] s);
    wr_hdr = hdr;
    for (int c = 0; c < NCH; c++) wr_dat[c*SW +: SW] = s;
  endtask

  task automatic wr_pulse(logic [3:0] hdr, logic [11:0] s);
    wr = 1'b1; set_samp(hdr, s); tick(); wr = 1'b0;
  endtask

  task automatic wb_xfer(string nm, logic wr_en, logic [15:0] a, logic [31:0] d);
    int lat;
    if (!wr_en) expect_rd(nm, d);
    adr = a; we = wr_en; dat_i = d; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!wb_ack_o && lat < 20) begin @(negedge clk); lat++; end
    chk({nm, "_lat"}, lat, 1);
    tick(); cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic burst(string nm, logic [15:0] base, int n);
    int acks;
    acks = 0;
    adr = base; we = 1'b0; cti = CTI_INCR; cyc = 1'b1; stb = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      adr = base + 16'(4*i);
      cti = (i == n-1) ? CTI_END : CTI_INCR;
      @(negedge clk);
      if (wb_ack_o) acks++;
      tick();
    end
    cyc = 1'b0; stb = 1'b0;
    chk({nm, "_acks"}, 32'(acks), 32'(n));
  endtask

  task automatic clear_fifos();
    fifo_rst = 1'b1; tick(); fifo_rst = 1'b0; tick(); tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] lo, hi;
    logic [31:0] e;
    int w;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_ack", 32'(wb_ack_o), 0);
    chk("rst_dat", wb_dat_o, 0);
    chk("rst_pempty", 32'(prog_empty_o), 32'hFFF);

    // pairs pack low-first, classic reads with one-cycle latency
    wr_pulse(4'hA, 12'd1); wr_pulse(4'hA, 12'd2);
    wr_pulse(4'hA, 12'd3); wr_pulse(4'hA, 12'd4);
    tick(); tick();
    chk("pe_loaded", 32'(prog_empty_o), 0);
    wb_xfer("t1_w0", 1'b0, 16'h0000, 32'hA002A001);
    wb_xfer("t1_w1", 1'b0, 16'h0000, 32'hA004A003);
    tick(); tick();
    chk("t1_pe0", 32'(prog_empty_o[0]), 1);
    wb_xfer("t1_stat_pe", 1'b0, 16'h7808, 32'h0000_0001);
    wb_xfer("t1_info", 1'b0, 16'h780C, 32'h000C_0200);
    clear_fifos();

    // empty read fills and sets underflow, W1C clears it
    wb_xfer("t3_empty", 1'b0, 16'h2800, EMPTY_FILL);
    wb_xfer("t3_unf", 1'b0, 16'h7804, 32'h0000_0020);
    chk("t3_pe5", 32'(prog_empty_o[5]), 1);
    wb_xfer("t3_w1c", 1'b1, 16'h7804, 32'h0000_0020);
    wb_xfer("t3_unf_clr", 1'b0, 16'h7804, 32'h0);
    wb_xfer("fifo_wr_ign", 1'b1, 16'h2800, 32'h1234_5678);
    wb_xfer("t3_empty2", 1'b0, 16'h2800, EMPTY_FILL);
    clear_fifos();

    // overfill by one word, drain with a full-depth burst
    for (int i = 0; i < 2*WD + 2; i++) wr_pulse(4'h5, 12'(i));
    tick(); tick();
    wb_xfer("t2_ovf", 1'b0, 16'h7800, 32'h0000_0FFF);
    for (int k = 0; k < WD; k++) expect_rd("t2_burst", {4'h5, 12'(2*k+1), 4'h5, 12'(2*k)});
    burst("t2_burst", 16'h1800, WD);
    wb_xfer("t2_after", 1'b0, 16'h1800, EMPTY_FILL);
    wb_xfer("t2_w1c", 1'b1, 16'h7800, 32'h0000_0008);
    wb_xfer("t2_ovf_clr", 1'b0, 16'h7800, 32'h0000_0FF7);
    clear_fifos();

    // programmable-empty threshold
    thresh = 10'd2;
    for (int i = 0; i < 6; i++) wr_pulse(4'h1, 12'(16 + i));
    tick(); tick();
    chk("t5_pe_lo", 32'(prog_empty_o[0]), 0);
    wb_xfer("t5_pop", 1'b0, 16'h0000, 32'h1011_1010);
    @(negedge clk);
    chk("t5_pe_still_lo", 32'(prog_empty_o[0]), 0);
    @(negedge clk);
    chk("t5_pe_hi", 32'(prog_empty_o[0]), 1);
    tick();
    thresh = '0;
    clear_fifos();

    // commit and pop on the same edge, ch1
    wr_pulse(4'h7, 12'd1); wr_pulse(4'h7, 12'd2);
    wr_pulse(4'h7, 12'd3); wr_pulse(4'h7, 12'd4);
    model.push_back(32'h7002_7001); model.push_back(32'h7004_7003);
    tick(); tick();
    for (int j = 0; j < 50; j++) begin
      lo = 12'(100 + 2*j); hi = 12'(101 + 2*j);
      e = model.pop_front();
      model.push_back({4'h7, hi, 4'h7, lo});
      expect_rd("t4_mix", e);
      adr = 16'h0800; we = 1'b0; cti = CTI_CLASSIC; cyc = 1'b1; stb = 1'b1;
      wr = 1'b1; set_samp(4'h7, lo);
      tick();
      set_samp(4'h7, hi);
      @(negedge clk);
      chk("t4_ack", 32'(wb_ack_o), 1);
      tick();
      cyc = 1'b0; stb = 1'b0; wr = 1'b0;
    end
    tick(); tick();
    w = model.size();
    chk("t4_model_len", 32'(w), 2);
    while (model.size() > 0) expect_rd("t4_tail", model.pop_front());
    burst("t4_tail", 16'h0800, 2);
    wb_xfer("t4_empty", 1'b0, 16'h0800, EMPTY_FILL);
    clear_fifos();

    // test-pattern select
    tp = 1'b1;
    fifo_rst = 1'b1; tick(); fifo_rst = 1'b0;
    wr_pulse(4'hC, 12'h0AB); wr_pulse(4'hC, 12'h0CD);
    tp = 1'b0;
    tick(); tick();
`ifdef LABX_TEST_PATTERN_EN
    wb_xfer("t6_ch2", 1'b0, 16'h1000, 32'hC003_C002);
    wb_xfer("t6_ch0", 1'b0, 16'h0000, 32'hC001_C000);
`else
    wb_xfer("t6_ch2", 1'b0, 16'h1000, 32'hC0CD_C0AB);
    wb_xfer("t6_ch0", 1'b0, 16'h0000, 32'hC0CD_C0AB);
`endif

    repeat (4) tick();
    chk("sb_drain", 32'(dat_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
